// File: rtl/timer_arbiter.sv
// ============================================================================
//  Module   : timer_arbiter
//  Brief    : Round-robin arbiter sharing one tick-counting timer among
//             N_REQ requesters; pulses a one-hot done when a grant expires.
//             Optional: TIMER_ARB_CANCEL_EN aborts a grant whose req drops.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] delay,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [CNT_W-1:0]       cnt
);

    localparam int c_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_FIN  = 2'd2;

    localparam logic [c_IDX_W:0]   c_N       = (c_IDX_W+1)'(N_REQ);
    localparam logic [c_IDX_W:0]   c_ONE     = (c_IDX_W+1)'(1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE = CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(N_REQ - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_done;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_tgt;
    logic [c_IDX_W-1:0] r_win;
    logic [c_IDX_W-1:0] r_last;

    logic [N_REQ-1:0]   w_gnt_nxt;
    logic [N_REQ-1:0]   w_done_nxt;
    logic               w_busy_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_tgt_nxt;
    logic [c_IDX_W-1:0] w_win_nxt;
    logic [c_IDX_W-1:0] w_last_nxt;

    logic [2*N_REQ-1:0] w_req2;
    logic [N_REQ-1:0]   w_rot;
    logic [c_IDX_W:0]   w_start;
    logic [c_IDX_W:0]   w_off;
    logic [c_IDX_W:0]   w_sum;
    logic [c_IDX_W:0]   w_wrap;
    logic               w_found;
    logic [c_IDX_W-1:0] w_win;
    logic [N_REQ-1:0]   w_win_oh;
    logic [CNT_W-1:0]   w_dly [N_REQ];
    logic [CNT_W-1:0]   w_tgt_load;
    logic               w_last_tick;
    logic               w_cancel;

    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_dly
            assign w_dly[g] = delay[g*CNT_W +: CNT_W];
        end
    endgenerate

    // Rotate the request vector so bit 0 is the requester after the last winner.
    assign w_start = {1'b0, r_last} + c_ONE;
    assign w_req2  = {req, req};
    assign w_rot   = N_REQ'(w_req2 >> w_start);

    always_comb begin : p_prio
        w_found = 1'b0;
        w_off   = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_found = 1'b1;
                w_off   = (c_IDX_W+1)'(j);
            end
        end
    end

    assign w_sum  = w_start + w_off;
    assign w_wrap = w_sum - c_N;
    assign w_win  = (w_sum >= c_N) ? w_wrap[c_IDX_W-1:0] : w_sum[c_IDX_W-1:0];

    always_comb begin : p_onehot
        w_win_oh        = '0;
        w_win_oh[w_win] = 1'b1;
    end

    // A zero delay behaves as one tick so the grant always completes.
    assign w_tgt_load  = (w_dly[w_win] == '0) ? c_CNT_ONE : w_dly[w_win];
    assign w_last_tick = (r_cnt >= (r_tgt - c_CNT_ONE));

`ifdef TIMER_ARB_CANCEL_EN
    assign w_cancel = ~req[r_win];
`else
    assign w_cancel = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin : p_state
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : p_next
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_found) w_state_nxt = c_RUN;
            c_RUN: begin
                if (w_cancel)                 w_state_nxt = c_IDLE;
                else if (tick && w_last_tick) w_state_nxt = c_FIN;
            end
            c_FIN:   w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin : p_out
        w_gnt_nxt  = r_gnt;
        w_done_nxt = '0;
        w_busy_nxt = r_busy;
        w_cnt_nxt  = r_cnt;
        w_tgt_nxt  = r_tgt;
        w_win_nxt  = r_win;
        w_last_nxt = r_last;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt  = w_win_oh;
                    w_busy_nxt = 1'b1;
                    w_cnt_nxt  = '0;
                    w_tgt_nxt  = w_tgt_load;
                    w_win_nxt  = w_win;
                end
            end
            c_RUN: begin
                if (w_cancel) begin
                    w_gnt_nxt  = '0;
                    w_busy_nxt = 1'b0;
                    w_last_nxt = r_win;
                end else if (tick) begin
                    if (w_last_tick) begin
                        w_gnt_nxt  = '0;
                        w_busy_nxt = 1'b0;
                        w_done_nxt = r_gnt;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
            end
            c_FIN:   w_last_nxt = r_win;
            default: begin
                w_gnt_nxt  = '0;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin : p_regs
        if (rst) begin
            r_gnt  <= '0;
            r_done <= '0;
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_tgt  <= '0;
            r_win  <= '0;
            r_last <= c_LAST_RST;
        end else begin
            r_gnt  <= w_gnt_nxt;
            r_done <= w_done_nxt;
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
            r_tgt  <= w_tgt_nxt;
            r_win  <= w_win_nxt;
            r_last <= w_last_nxt;
        end
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign busy = r_busy;
    assign cnt  = r_cnt;

endmodule

`default_nettype wire
